// File: rtl/md_sched_pkg.sv
// md_sched_pkg: MD opcode constants, scheduler states and opcode classifiers.
package md_sched_pkg;
  localparam logic [3:0] MD_NONE = 4'b0000;
  localparam logic [3:0] MTHI    = 4'b0010;
  localparam logic [3:0] MTLO    = 4'b0100;
  localparam logic [3:0] MFHI    = 4'b0110;
  localparam logic [3:0] MFLO    = 4'b1000;
  localparam logic [3:0] MULT    = 4'b0001;
  localparam logic [3:0] MULTU   = 4'b0011;
  localparam logic [3:0] DIV     = 4'b0101;
  localparam logic [3:0] DIVU    = 4'b0111;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[0];
  endfunction
  function automatic logic is_move(input logic [3:0] op);
    return op inside {MTHI, MTLO, MFHI, MFLO};
  endfunction
endpackage

// File: rtl/md_sched.sv
// md_sched: issue gating, latency counting and D-stage stall for the HI/LO multiply-divide unit.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_e_valid,
  input  logic [3:0]       i_e_md_op,
  input  logic             i_e_flush,
  input  logic             i_d_md_use,
  output logic [3:0]       o_md_start,
  output logic             o_md_commit,
  output logic             o_busy,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_md_cnt,
  output logic             o_proto_err
);
  if (MULT_LAT < 1 || MULT_LAT > 2**CNT_W || DIV_LAT < 1 || DIV_LAT > 2**CNT_W)
    $error("md_sched: latency does not fit the counter");
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_commit;
  logic             r_perr;
  logic             w_live;
  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  assign w_live   = i_e_valid & ~i_e_flush;
  assign w_busy   = r_state != S_IDLE;
  assign w_accept = w_live & is_muldiv(i_e_md_op) & ~w_busy;
  assign w_last   = r_cnt == (r_state == S_DIV ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1));
  // Moves reach the unit only when idle; the commit cycle is already idle, so MF* reads the old value.
  assign o_md_start  = (w_accept | (w_live & is_move(i_e_md_op) & ~w_busy)) ? i_e_md_op : MD_NONE;
  assign o_stall     = i_d_md_use & (w_busy | w_accept);
  assign o_busy      = w_busy;
  assign o_md_commit = r_commit;
  assign o_md_cnt    = r_cnt;
  assign o_proto_err = r_perr;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_commit <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      r_perr   <= r_perr | (w_live & (i_e_md_op != MD_NONE) & w_busy);
      if (!w_busy) begin
        if (w_accept) begin
          r_state <= i_e_md_op[2] ? S_DIV : S_MUL;
          r_cnt   <= '0;
        end
      end else if (w_last) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_commit <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule
